// File: rtl/sync_down_counter_if.sv
// Control/status bundle for the programmable down-counter/timer.
// The master drives the controls; the counter (slave) returns count and status.
interface sync_down_counter_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             enable;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, load_value, start, enable, auto_reload,
        input  count, tc, busy, done
    );

    modport slave (
        input  load, load_value, start, enable, auto_reload,
        output count, tc, busy, done
    );
endinterface

// File: rtl/sync_down_counter.sv
// Programmable down-counter/timer: load a reload value, count to zero on enabled
// edges, pulse tc at terminal count, then stop (one-shot) or reload (auto-reload).
module sync_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    sync_down_counter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        state_t           st;
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] rld;
        logic             tc;
    } regs_t;

    regs_t q, d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.st  <= IDLE;
            q.cnt <= '0;
            q.rld <= '0;
            q.tc  <= 1'b0;
        end else begin
            q <= d;
        end
    end

    // Priority: load > start > counting. tc defaults low so it is a one-cycle pulse.
    always_comb begin
        d    = q;
        d.tc = 1'b0;
        if (bus.load) begin
            d.rld = bus.load_value;
            d.cnt = bus.load_value;
            d.st  = IDLE;
        end else if (bus.start && (q.rld != '0)) begin
            d.cnt = q.rld;
            d.st  = RUN;
        end else begin
            case (q.st)
                RUN: begin
                    if (bus.enable) begin
                        if (q.cnt > WIDTH'(1)) begin
                            d.cnt = q.cnt - WIDTH'(1);
                        end else if (q.cnt == WIDTH'(1)) begin
                            d.tc = 1'b1;
                            if (bus.auto_reload) begin
                                d.cnt = q.rld;
                            end else begin
                                d.cnt = '0;
                                d.st  = DONE;
                            end
                        end
                    end
                end
                IDLE:    d.st = IDLE;
                DONE:    d.st = DONE;
                default: d.st = IDLE;
            endcase
        end
    end

    assign bus.count = q.cnt;
    assign bus.tc    = q.tc;
    assign bus.busy  = (q.st == RUN);
    assign bus.done  = (q.st == DONE);
endmodule

// File: tb/tb_sync_down_counter.sv
// Directed bench for sync_down_counter: one-shot, auto-reload, pause, zero reload,
// async reset mid-run and load/start/terminal-count collisions.
module tb_sync_down_counter;
    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;

    sync_down_counter_if #(.WIDTH(4)) bus ();

    sync_down_counter #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input string tag, input int c, input bit t, input bit b, input bit dn);
        chk({tag, ".count"}, 32'(bus.count), 32'(c));
        chk({tag, ".tc"},    32'(bus.tc),    32'(t));
        chk({tag, ".busy"},  32'(bus.busy),  32'(b));
        chk({tag, ".done"},  32'(bus.done),  32'(dn));
    endtask

    task automatic do_load(input int v);
        bus.load = 1'b1; bus.load_value = 4'(v);
        tick();
        bus.load = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        bus.load = 1'b0; bus.load_value = '0; bus.start = 1'b0;
        bus.enable = 1'b1; bus.auto_reload = 1'b0;
        #1;
        st("rst", 0, 0, 0, 0);
        tick();
        reset = 1'b1;

        // one-shot from 5
        do_load(5);
        st("os.load", 5, 0, 0, 0);
        do_start();
        st("os.start", 5, 0, 1, 0);
        tick(); st("os4", 4, 0, 1, 0);
        tick(); st("os3", 3, 0, 1, 0);
        tick(); st("os2", 2, 0, 1, 0);
        tick(); st("os1", 1, 0, 1, 0);
        tick(); st("os0", 0, 1, 0, 1);
        tick(); st("os.hold", 0, 0, 0, 1);
        tick(); st("os.hold2", 0, 0, 0, 1);

        // auto-reload from 3
        do_load(3);
        bus.auto_reload = 1'b1;
        do_start();
        st("ar.start", 3, 0, 1, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            st($sformatf("ar.k%0d", k), 3 - (k % 3), (k % 3) == 0, 1, 0);
        end

        // auto-reload with N=1: tc every enabled cycle
        do_load(1);
        do_start();
        st("ar1.start", 1, 0, 1, 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            st($sformatf("ar1.k%0d", k), 1, 1, 1, 0);
        end
        bus.auto_reload = 1'b0;

        // pause at count 2 for 3 cycles
        do_load(4);
        do_start();
        st("pz.start", 4, 0, 1, 0);
        tick(); st("pz3", 3, 0, 1, 0);
        tick(); st("pz2", 2, 0, 1, 0);
        bus.enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(); st($sformatf("pz.hold%0d", k), 2, 0, 1, 0);
        end
        bus.enable = 1'b1;
        tick(); st("pz1", 1, 0, 1, 0);
        tick(); st("pz0", 0, 1, 0, 1);

        // zero reload: start ignored
        do_load(0);
        st("z.load", 0, 0, 0, 0);
        do_start();
        st("z.start", 0, 0, 0, 0);
        tick(); st("z.idle", 0, 0, 0, 0);
        do_load(1);
        do_start();
        st("z1.start", 1, 0, 1, 0);
        tick(); st("z1.tc", 0, 1, 0, 1);

        // async reset mid-run from 9
        do_load(9);
        do_start();
        tick(); tick();
        st("rr.run", 7, 0, 1, 0);
        #2 reset = 1'b0;
        #1 st("rr.async", 0, 0, 0, 0);
        #2 reset = 1'b1;
        tick(); st("rr.post", 0, 0, 0, 0);
        do_start();
        st("rr.start0", 0, 0, 0, 0);

        // start collides with terminal count: start wins
        do_load(2);
        do_start();
        tick(); st("sc1", 1, 0, 1, 0);
        do_start();
        st("sc.restart", 2, 0, 1, 0);

        // load and start together at count 1: load wins
        tick(); st("ls1", 1, 0, 1, 0);
        bus.load = 1'b1; bus.load_value = 4'd7; bus.start = 1'b1;
        tick();
        bus.load = 1'b0; bus.start = 1'b0;
        st("ls.both", 7, 0, 0, 0);
        tick(); st("ls.idle", 7, 0, 0, 0);
        do_start();
        st("ls.start", 7, 0, 1, 0);
        for (int c = 6; c >= 1; c--) begin
            tick(); st($sformatf("ls%0d", c), c, 0, 1, 0);
        end
        tick(); st("ls0", 0, 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/sync_down_counter.md
# sync_down_counter

Programmable synchronous down-counter/timer, the counting-down counterpart to the 4-bit up counter in the synchronous counter set. Loads a reload value, counts down to zero on enabled clock edges and flags the terminal count. Runs in one-shot or auto-reload mode. Serves as a countdown timer or period generator beside the up counter.

## Interface
- WIDTH, default 4: width of the count and reload value.

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  capture load_value into the reload register and count; aborts any run.
- load_value  input  WIDTH  value captured on load.
- start  input  1  begin (or restart) a countdown from the reload register.
- enable  input  1  count gate; when low in RUN, count and state hold (pause).
- auto_reload  input  1  1 = reload on terminal count and keep running; 0 = one-shot.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, high for exactly one cycle per event.
- busy  output  1  high while in RUN (decoded from the state register).
- done  output  1  high while in DONE (decoded from the state register).

## Operation
- Internal: reload register (WIDTH), count register, 2-bit state {IDLE, RUN, DONE}.
- Reset (reset=0, asynchronous): state=IDLE, count=0, reload=0, tc=0; therefore busy=0, done=0.
- Priority each edge: load > start > counting.
- load=1, any state: reload<=load_value, count<=load_value, state<=IDLE, tc<=0. No tc for an aborted run.
- start=1 (load=0), any state:
  - If reload != 0: count<=reload, state<=RUN.
  - If reload == 0: ignored; state and count unchanged.
  - In RUN, start restarts from reload.
- IDLE: count holds. tc=0.
- RUN, enable=0: count and state hold. tc=0.
- RUN, enable=1, count>1: count<=count-1, tc<=0.
- RUN, enable=1, count==1, auto_reload=0: count<=0, tc<=1, state<=DONE.
- RUN, enable=1, count==1, auto_reload=1: count<=reload, tc<=1, state stays RUN. Count never shows 0 in this mode.
- DONE: count holds 0. Leaves only on load (to IDLE) or start (to RUN).
- auto_reload is sampled at the count==1 edge only. Changing it mid-run takes effect at the next terminal count.
- Arithmetic is unsigned, modulo 2^WIDTH. Decrement never wraps, because count==0 is never decremented.

## Timing
- Load latency: count shows load_value one cycle after the load edge.
- Start latency: count = reload and busy=1 on the cycle after the start edge.
- One-shot with reload N and enable held high: tc and done assert together N cycles after busy first asserts.
- Auto-reload with reload N and enable held high: tc period is exactly N cycles. N=1 gives tc high every enabled cycle.
- Each cycle with enable=0 in RUN stretches the interval by one cycle.
- tc deasserts on the following edge unless a new terminal event occurs (auto-reload only).
- Reset asserted mid-run clears all outputs immediately, with no clock required. After deassertion the first edge behaves as IDLE.
- Simultaneous load and start: load wins, state=IDLE, start is lost.
- Simultaneous start and terminal count: start wins, count<=reload, tc=0.

## Test plan
- Reset, then load_value=5 with load, then start with enable=1 and auto_reload=0:
  - count sequence 5,4,3,2,1,0.
  - tc=1 for exactly the cycle where count=0.
  - done=1 and busy=0 from that cycle onward; count holds 0.
- load 3, start with auto_reload=1 and enable=1 for 10 cycles:
  - count 3,2,1,3,2,1,...
  - tc pulses every 3 cycles, coincident with count returning to 3.
  - busy stays 1 and done never asserts.
- load 4, start, then enable=0 for 3 cycles at count=2:
  - count holds 2 during the pause and busy stays 1.
  - tc arrives 3 cycles later than the unpaused case.
- load 0, then start:
  - state stays IDLE; busy=0, tc=0, count=0.
  - Then load 1 and start: tc asserts one enabled cycle after busy asserts.
- Countdown running from 9 (WIDTH=4):
  - Assert reset low for half a cycle mid-run: count=0, tc=0, busy=0 immediately, before any clock edge.
  - After release, start: ignored, since reload is 0.
- load 2, start, then drive load (load_value=7) and start in the same cycle at count=1:
  - count=7, state=IDLE, tc stays 0.
  - Then start alone: count 7 down to 0 in one-shot mode.
